// File: rtl/stat_scan_pkg.sv
// Shared definitions for the status scan reader: FSM state encoding and
// parameter defaults.
package stat_scan_pkg;

   localparam int DATA_W_DEF  = 16;
   localparam int TIMEOUT_DEF = 15;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_RDY,
      ST_SHIFT,
      ST_DONE
   } state_e;

endpackage

// File: rtl/stat_shreg.sv
// Right-shifting capture register: parallel load, zero-fill shift, or hold.
module stat_shreg #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              shift,
   input  logic [DATA_W-1:0] load_data,
   output logic              lsb
);

   logic [DATA_W-1:0] shreg_q, shreg_d;

   always_comb begin
      shreg_d = shreg_q;
      if (load)
         shreg_d = load_data;
      else if (shift)
         shreg_d = {1'b0, shreg_q[DATA_W-1:1]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         shreg_q <= '0;
      else
         shreg_q <= shreg_d;
   end

   assign lsb = shreg_q[0];

endmodule

// File: rtl/stat_scan_rd.sv
// Status read sequencer: waits for a valid status word, snapshots it and
// serialises it LSB first under scan-chain back-pressure.
//
//   state    | meaning
//   IDLE     | waiting for rd_req
//   WAIT_RDY | waiting for stat_ready, timeout counter running
//   SHIFT    | presenting shreg[0] on scan_out, one bit per shift_en
//   DONE     | one-cycle rd_done pulse, rd_err reflects timeout
module stat_scan_rd
   import stat_scan_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] stat_rdata,
   input  logic              stat_ready,
   input  logic              rd_req,
   input  logic              shift_en,
   output logic              scan_out,
   output logic              scan_valid,
   output logic [DATA_W-1:0] snap_data,
   output logic              rd_busy,
   output logic              rd_done,
   output logic              rd_err
);

   localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int TMO_W = $clog2(TIMEOUT + 1);

   state_e            state_q, state_d;
   logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
   logic [DATA_W-1:0] snap_q, snap_d;
   logic              err_q, err_d;
   logic              valid_q, valid_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              sh_load, sh_shift;

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      tmo_cnt_d = tmo_cnt_q;
      snap_d    = snap_q;
      err_d     = err_q;
      sh_load   = 1'b0;
      sh_shift  = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (rd_req) begin
               state_d   = ST_WAIT_RDY;
               err_d     = 1'b0;
               tmo_cnt_d = '0;
            end
         end
         ST_WAIT_RDY: begin
            if (stat_ready) begin
               sh_load   = 1'b1;
               snap_d    = stat_rdata;
               bit_cnt_d = '0;
               state_d   = ST_SHIFT;
            end else if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
         end
         ST_SHIFT: begin
            if (shift_en) begin
               sh_shift = 1'b1;
               // Counter holds on the last bit so it never wraps.
               if (bit_cnt_q == BIT_W'(DATA_W - 1))
                  state_d = ST_DONE;
               else
                  bit_cnt_d = bit_cnt_q + 1'b1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // Status outputs are registered copies of the upcoming state.
      valid_d = (state_d == ST_SHIFT);
      busy_d  = (state_d != ST_IDLE);
      done_d  = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= '0;
         tmo_cnt_q <= '0;
         snap_q    <= '0;
         err_q     <= 1'b0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         tmo_cnt_q <= tmo_cnt_d;
         snap_q    <= snap_d;
         err_q     <= err_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   // Every load is fully shifted out (or cleared by reset), so the LSB is 0
   // whenever the FSM is outside SHIFT.
   stat_shreg #(.DATA_W(DATA_W)) u_shreg (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (sh_load),
      .shift     (sh_shift),
      .load_data (stat_rdata),
      .lsb       (scan_out)
   );

   assign scan_valid = valid_q;
   assign snap_data  = snap_q;
   assign rd_busy    = busy_q;
   assign rd_done    = done_q;
   assign rd_err     = err_q;

endmodule

// File: tb/tb_stat_scan_rd.sv
// Self-checking bench for stat_scan_rd: directed and randomised reads checked
// against a transaction-level model of the read/serialise behaviour.
module tb_stat_scan_rd;

   localparam int DATA_W  = 16;
   localparam int TIMEOUT = 15;

   logic              clk;
   logic              rst_n;
   logic [DATA_W-1:0] stat_rdata;
   logic              stat_ready;
   logic              rd_req;
   logic              shift_en;
   logic              scan_out;
   logic              scan_valid;
   logic [DATA_W-1:0] snap_data;
   logic              rd_busy;
   logic              rd_done;
   logic              rd_err;

   int n_vec = 0;
   int n_err = 0;
   logic [DATA_W-1:0] exp_snap = '0;

   stat_scan_rd #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .stat_rdata (stat_rdata),
      .stat_ready (stat_ready),
      .rd_req     (rd_req),
      .shift_en   (shift_en),
      .scan_out   (scan_out),
      .scan_valid (scan_valid),
      .snap_data  (snap_data),
      .rd_busy    (rd_busy),
      .rd_done    (rd_done),
      .rd_err     (rd_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_vec++;
      assert (obs === exp_v)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".scan_out"},   scan_out,   0);
      chk({tag, ".scan_valid"}, scan_valid, 0);
      chk({tag, ".rd_busy"},    rd_busy,    0);
      chk({tag, ".rd_done"},    rd_done,    0);
      chk({tag, ".rd_err"},     rd_err,     0);
      chk({tag, ".snap_data"},  snap_data,  0);
   endtask

   // One read transaction. d = number of WAIT_RDY cycles with stat_ready low
   // before it rises (d >= TIMEOUT means it never rises in time); pct = % of
   // cycles with shift_en low; stall_len = cycles of shift_en low while the
   // first bit is presented; req_mode 1 = extra rd_req mid-shift, 2 = rd_req
   // during the DONE cycle.
   task automatic run_read(input logic [DATA_W-1:0] w, input int d, input int pct,
                           input int stall_len, input int req_mode);
      int c, popped, done_at, first, stall_cnt;
      bit tmo, exp_valid;
      tmo       = (d >= TIMEOUT);
      first     = d + 2;
      done_at   = tmo ? TIMEOUT + 1 : -1;
      popped    = 0;
      stall_cnt = 0;

      stat_rdata = w;
      stat_ready = (d == 0);
      shift_en   = 1'b0;
      rd_req     = 1'b1;
      tick();
      rd_req = 1'b0;
      c = 1;
      while (1) begin
         exp_valid = !tmo && (c >= first) && (popped < DATA_W);
         chk("scan_valid", scan_valid, exp_valid);
         if (exp_valid) chk("scan_out", scan_out, w[popped]);
         chk("rd_done", rd_done, (c == done_at));
         chk("rd_busy", rd_busy, 1'b1);
         chk("rd_err", rd_err, (tmo && c == done_at));
         if (c == done_at) break;
         if (c > 200) begin
            n_vec++;
            n_err++;
            $error("FAIL rd_done_budget observed=no_done expected=done_by_cycle_200");
            break;
         end

         stat_ready = (c < d + 1) ? 1'b0 : (c == d + 1) ? 1'b1 : 1'($urandom);
         stat_rdata = (c <= d + 1) ? w : DATA_W'($urandom);
         if (exp_valid && popped == 0 && stall_cnt < stall_len) begin
            shift_en = 1'b0;
            stall_cnt++;
         end else begin
            shift_en = ($urandom_range(0, 99) >= pct);
         end
         if (req_mode == 1 && c == first + 5) begin
            rd_req     = 1'b1;
            stat_rdata = 16'hFFFF;
         end else begin
            rd_req = 1'b0;
         end
         if (exp_valid && shift_en) begin
            popped++;
            if (popped == DATA_W) done_at = c + 1;
         end
         tick();
         c++;
      end

      if (!tmo) exp_snap = w;
      rd_req   = (req_mode == 2);
      shift_en = 1'b0;
      tick();
      rd_req = 1'b0;
      chk("post.rd_busy",    rd_busy,    0);
      chk("post.rd_done",    rd_done,    0);
      chk("post.scan_valid", scan_valid, 0);
      chk("post.snap_data",  snap_data,  exp_snap);
      chk("post.rd_err",     rd_err,     tmo);
      tick();
      chk("noqueue.rd_busy", rd_busy, 0);
   endtask

   initial begin
      logic [DATA_W-1:0] w;
      rst_n      = 1'b0;
      stat_rdata = '0;
      stat_ready = 1'b0;
      rd_req     = 1'b0;
      shift_en   = 1'b0;
      repeat (3) tick();
      chk_all_zero("reset");
      rst_n = 1'b1;

      // nominal, then back-pressure, timeout, busy request, boundary
      run_read(16'hA5C3, 0, 0, 0, 0);
      run_read(16'h0001, 0, 0, 5, 0);
      run_read(16'h7E81, 100, 0, 0, 0);
      run_read(16'h5A0F, 0, 0, 0, 1);
      run_read(16'($urandom), TIMEOUT - 1, 0, 0, 2);
      run_read(16'h3C3C, 1, 0, 0, 0);

      repeat (6) run_read(16'($urandom), $urandom_range(0, 4), 30, 0, 0);

      // reset while bit 7 is on scan_out
      w          = 16'($urandom);
      stat_rdata = w;
      stat_ready = 1'b1;
      shift_en   = 1'b1;
      rd_req     = 1'b1;
      tick();
      rd_req = 1'b0;
      repeat (8) tick();
      chk("rst_mid.bit7", scan_out, w[7]);
      chk("rst_mid.valid", scan_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      chk_all_zero("rst_mid");
      exp_snap = '0;
      repeat (2) begin
         tick();
         chk("rst_mid.no_done", rd_done, 0);
      end
      rst_n = 1'b1;
      run_read(16'($urandom), 0, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/stat_scan_rd.md
STAT_SCAN_RD -- requirements
Module: stat_scan_rd

Interface
REQ-001 Parameter DATA_W, default 16, width of status word and shift register.
REQ-002 Parameter TIMEOUT, default 15, maximum number of WAIT_RDY cycles before an error abort.
REQ-003 Port clk  input  1  clock; all state changes on its rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port stat_rdata  input  DATA_W  status word from the status register.
REQ-006 Port stat_ready  input  1  stat_rdata is valid this cycle.
REQ-007 Port rd_req  input  1  single-cycle request to read and serialise one status word.
REQ-008 Port shift_en  input  1  scan-chain accept; the current scan_out bit is consumed this cycle.
REQ-009 Port scan_out  output  1  serial status bit, LSB first.
REQ-010 Port scan_valid  output  1  scan_out is valid.
REQ-011 Port snap_data  output  DATA_W  parallel copy of the last captured word.
REQ-012 Port rd_busy  output  1  high in any state other than IDLE.
REQ-013 Port rd_done  output  1  one-cycle pulse at end of transaction.
REQ-014 Port rd_err  output  1  set on timeout abort; held until the next accepted rd_req.

Function
REQ-015 FSM states SHALL be IDLE, WAIT_RDY, SHIFT and DONE; all outputs registered.
REQ-016 IDLE: rd_req=1 -> WAIT_RDY next cycle, clearing rd_err and the timeout counter to 0.
REQ-017 WAIT_RDY, stat_ready=1: on that edge, load stat_rdata into the shift register and snap_data, clear the bit counter, and go to SHIFT.
REQ-018 WAIT_RDY, stat_ready=0: increment the timeout counter.
REQ-019 WAIT_RDY timeout: if the counter equals TIMEOUT-1 with stat_ready=0, set rd_err=1, leave snap_data unchanged, and go to DONE.
REQ-020 SHIFT: scan_valid=1 and scan_out=shreg[0].
REQ-021 SHIFT, shift_en=1: shift right by one (zero fill) and increment the bit counter.
REQ-022 SHIFT, shift_en=0: hold scan_out, the shift register and the counter (back-pressure).
REQ-023 SHIFT end: when shift_en=1 and the bit counter equals DATA_W-1 -> DONE; scan_valid=0 from the next cycle.
REQ-024 DONE: rd_done=1 for exactly one cycle, then IDLE.
REQ-025 Latency: with stat_ready already high, rd_req in cycle N gives first scan_valid in cycle N+2; with shift_en held high, rd_done occurs in cycle N+2+DATA_W.
REQ-026 rd_req while rd_busy=1 SHALL be ignored, with no queueing.
REQ-027 rd_req in the same cycle as a DONE pulse SHALL be ignored; it is accepted only in IDLE.
REQ-028 stat_ready toggling during SHIFT SHALL have no effect; the captured word is frozen.
REQ-029 Counter widths: the bit counter is clog2(DATA_W) bits and the timeout counter is clog2(TIMEOUT+1) bits, with no wrap inside a transaction.

Reset
REQ-030 While rst_n=0: state=IDLE; scan_out, scan_valid, rd_busy, rd_done and rd_err are 0; snap_data, the shift register and both counters are 0.
REQ-031 Reset asserted mid-transaction SHALL abort immediately with no rd_done pulse.
REQ-032 After rst_n deasserts, the first rd_req is accepted in the first IDLE cycle.

Structure
REQ-033 Shared package stat_scan_pkg SHALL hold the FSM state enum, the DATA_W default (16) and the TIMEOUT default (15).
REQ-034 The shift register with load, shift and hold SHALL be one sub-module, stat_shreg, parameterised by DATA_W; the FSM and counters stay in stat_scan_rd.

Verification
REQ-035 Bench SHALL cover a nominal read:
- Stimulus: stat_ready=1, stat_rdata=16'hA5C3, one-cycle rd_req, shift_en=1.
- Response: scan_out sequence 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1; snap_data=16'hA5C3; rd_done exactly 18 cycles after rd_req; rd_err=0.
REQ-036 Bench SHALL cover back-pressure:
- Stimulus: stat_rdata=16'h0001; shift_en=0 for 5 cycles after the first bit.
- Response: scan_out holds 1 and scan_valid holds 1 across the stall; total bits shifted = 16; rd_done delayed by 5 cycles.
REQ-037 Bench SHALL cover timeout:
- Stimulus: stat_ready=0 throughout; one rd_req.
- Response: rd_err=1 and rd_done pulse 16 cycles after rd_req; scan_valid never asserted; snap_data unchanged.
REQ-038 Bench SHALL cover a busy request:
- Stimulus: a second rd_req mid-SHIFT with stat_rdata changed to 16'hFFFF.
- Response: the first word completes unchanged; exactly one rd_done; the FSM returns to IDLE.
REQ-039 Bench SHALL cover reset mid-shift:
- Stimulus: rst_n=0 at bit 7.
- Response: all outputs 0 on the next sample; no rd_done; a fresh rd_req after release completes a full 16-bit transfer.
